ahbl_apb_bridge: RTL
====================

AHBL_APB_BRIDGE -- requirements
Module: ahbl_apb_bridge

Interface
REQ-001 SHALL have parameter W_ADDR, default 16, giving the APB address width; AHB address bits above W_ADDR-1 are ignored.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port ahbls_hready_resp  out  1  AHB-Lite responder HREADYOUT.
REQ-005 SHALL have port ahbls_hready  in  1  bus-level HREADY.
REQ-006 SHALL have port ahbls_hresp  out  1  AHB error response.
REQ-007 SHALL have port ahbls_haddr  in  32  address-phase address.
REQ-008 SHALL have ports ahbls_hwrite  in  1, ahbls_htrans  in  2 and ahbls_hsize  in  3, carrying the address-phase controls.
REQ-009 SHALL have ports ahbls_hwdata  in  32 (data-phase write data) and ahbls_hrdata  out  32 (read data).
REQ-010 SHALL have ports apbm_paddr  out  W_ADDR, apbm_psel  out  1, apbm_penable  out  1 and apbm_pwrite  out  1, forming the APB requester controls.
REQ-011 SHALL have ports apbm_pstrb  out  4 (byte strobes) and apbm_pwdata  out  32 (write data).
REQ-012 SHALL have ports apbm_prdata  in  32, apbm_pready  in  1 and apbm_pslverr  in  1, carrying the APB completer response.

Function
REQ-013 SHALL accept an address phase when ahbls_hready=1 and ahbls_htrans[1]=1 in state IDLE, DONE or ERR2; IDLE/BUSY transfers SHALL get a zero-wait OKAY and no APB access.
REQ-014 SHALL register paddr=haddr[W_ADDR-1:0], pwrite=hwrite and pstrb on acceptance; on reads pstrb SHALL be 4'h0.
REQ-015 SHALL compute write pstrb as follows: hsize=0 gives 4'b0001<<haddr[1:0]; hsize=1 gives 4'b0011<<{haddr[1],1'b0}; hsize=2 gives 4'hf.
REQ-016 SHALL treat an accepted transfer with hsize>2 as an error: go to ERR1 with no APB access (psel stays 0).
REQ-017 SHALL implement states IDLE, SETUP, ACCESS, DONE, ERR1, ERR2; from IDLE/DONE/ERR2 it SHALL go to SETUP on an accepted legal transfer, ERR1 on an accepted illegal one, else IDLE.
REQ-018 In SETUP the block SHALL drive psel=1, penable=0 and hready_resp=0, then SHALL go to ACCESS unconditionally.
REQ-019 In ACCESS the block SHALL drive psel=1, penable=1 and hready_resp=0, and SHALL hold there while pready=0 (unbounded wait).
REQ-020 In ACCESS with pready=1, the block SHALL go to DONE if pslverr=0 and to ERR1 if pslverr=1; on reads it SHALL capture prdata into hrdata on the same edge.
REQ-021 In DONE the block SHALL drive hready_resp=1, hresp=0 and psel=0, with hrdata stable for the whole cycle.
REQ-022 ERR1 SHALL drive hresp=1 and hready_resp=0, then go to ERR2; ERR2 SHALL drive hresp=1 and hready_resp=1 (two-cycle AHB error).
REQ-023 SHALL drive apbm_pwdata combinationally from ahbls_hwdata; this is legal because the AHB master holds hwdata throughout the stalled data phase.
REQ-024 paddr, pwrite and pstrb SHALL be stable from SETUP through the final ACCESS cycle.
REQ-025 With a zero-wait completer, each access SHALL take exactly 3 data-phase cycles (SETUP, ACCESS, DONE), and a back-to-back address phase accepted in DONE SHALL produce SETUP on the next cycle with no idle gap.
REQ-026 In IDLE the block SHALL drive hready_resp=1, hresp=0, psel=0 and penable=0.
REQ-027 penable=1 SHALL never occur without psel=1, and psel SHALL never be asserted for two consecutive transfers without an intervening SETUP.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL enter IDLE and set psel=0, penable=0, hready_resp=1, hresp=0, paddr=0, pwrite=0, pstrb=0 and hrdata=0.
REQ-029 A reset during SETUP or ACCESS SHALL abandon the transfer: psel=0 from the next cycle, and no DONE or ERR response is issued.

Verification
REQ-030 The bench SHALL cover a word write: haddr=0x1234, hwdata=0xCAFEF00D, hsize=2, pready=1 -> one SETUP then one ACCESS with paddr=0x1234, pstrb=0xf, pwdata=0xCAFEF00D, and hready_resp=1 on the 3rd data-phase cycle.
REQ-031 The bench SHALL cover a byte write: haddr=0x0003, hsize=0 -> pstrb=4'b1000; a halfword write at haddr=0x0002 -> pstrb=4'b1100.
REQ-032 The bench SHALL cover a read with wait states: pready held low for 4 ACCESS cycles, prdata=0x5A5A0001 -> hready_resp low for 6 cycles, then hrdata=0x5A5A0001 with hresp=0.
REQ-033 The bench SHALL cover a slave error: pslverr=1 with pready=1 -> hresp=1/hready_resp=0, then hresp=1/hready_resp=1; an hsize=3 access -> the same response with psel never asserted.
REQ-034 The bench SHALL cover back-to-back and idle traffic: two consecutive NONSEQ reads -> the second SETUP directly follows the first DONE; htrans=IDLE -> hready_resp=1 and psel=0.
REQ-035 The bench SHALL cover reset during ACCESS: rst=1 while penable=1 -> the next cycle shows psel=0, penable=0 and hready_resp=1.

Source files
------------

// File: rtl/ahbl_apb_bridge.sv
// rtl/ahbl_apb_bridge.sv - AHB-Lite responder to APB requester bridge
//
// Purpose: converts single AHB-Lite transfers into APB SETUP/ACCESS
// sequences, stalling the AHB data phase until the APB completer responds.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ahbls_*             AHB-Lite responder (address phase in, data phase out)
//   apbm_*              APB requester (controls/write data out, response in)
module ahbl_apb_bridge #(
  parameter int W_ADDR = 16
) (
  input  logic              clk,
  input  logic              rst,

  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [31:0]       ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [31:0]       ahbls_hwdata,
  output logic [31:0]       ahbls_hrdata,

  output logic [W_ADDR-1:0] apbm_paddr,
  output logic              apbm_psel,
  output logic              apbm_penable,
  output logic              apbm_pwrite,
  output logic [3:0]        apbm_pstrb,
  output logic [31:0]       apbm_pwdata,
  input  logic [31:0]       apbm_prdata,
  input  logic              apbm_pready,
  input  logic              apbm_pslverr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [W_ADDR-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic              accept;
  logic              illegal;
  logic [3:0]        wstrb;

  // Upper address bits and htrans[0] (SEQ vs NONSEQ) carry no meaning here.
  logic              unused_inputs;
  assign unused_inputs = ^{ahbls_haddr, ahbls_htrans[0]};

  // A new address phase can only be taken while the previous data phase is
  // finishing (DONE/ERR2) or the bridge is idle.
  assign accept  = ahbls_hready && ahbls_htrans[1] &&
                   (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR2);
  assign illegal = (ahbls_hsize > 3'd2);

  always_comb begin
    wstrb = 4'h0;
    case (ahbls_hsize)
      3'd0:    wstrb = 4'b0001 << ahbls_haddr[1:0];
      3'd1:    wstrb = 4'b0011 << {ahbls_haddr[1], 1'b0};
      3'd2:    wstrb = 4'hf;
      default: wstrb = 4'h0;
    endcase
  end

  // State register and data-path flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= 4'h0;
      hrdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Next-state and data-path update
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    hrdata_d = hrdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          state_d  = illegal ? S_ERR1 : S_SETUP;
          paddr_d  = ahbls_haddr[W_ADDR-1:0];
          pwrite_d = ahbls_hwrite;
          pstrb_d  = ahbls_hwrite ? wstrb : 4'h0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (apbm_pready) begin
          state_d = apbm_pslverr ? S_ERR1 : S_DONE;
          if (!pwrite_q) begin
            hrdata_d = apbm_prdata;
          end
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from state
  always_comb begin
    apbm_psel         = 1'b0;
    apbm_penable      = 1'b0;
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    case (state_q)
      S_SETUP: begin
        apbm_psel         = 1'b1;
        ahbls_hready_resp = 1'b0;
      end
      S_ACCESS: begin
        apbm_psel         = 1'b1;
        apbm_penable      = 1'b1;
        ahbls_hready_resp = 1'b0;
      end
      S_ERR1: begin
        ahbls_hresp       = 1'b1;
        ahbls_hready_resp = 1'b0;
      end
      S_ERR2: begin
        ahbls_hresp       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign apbm_paddr   = paddr_q;
  assign apbm_pwrite  = pwrite_q;
  assign apbm_pstrb   = pstrb_q;
  // The AHB master holds hwdata for the whole stalled data phase.
  assign apbm_pwdata  = ahbls_hwdata;
  assign ahbls_hrdata = hrdata_q;

endmodule
